// File: rtl/ram_line_ctrl.sv
// ram_line_ctrl: expands one cache line fill/evict into LINE_WORDS consecutive
// single-word accesses on a single-port memory with fixed read latency.
module ram_line_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10,
  parameter int LINE_WORDS = 4,
  parameter int RAM_LAT = 1,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_wdata_req,
  output logic [IW-1:0]     o_wdata_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rdata_valid,
  output logic [IW-1:0]     o_rdata_idx,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_read,
  output logic              o_ram_write,
  output logic [DATA_W-1:0] o_ram_data_in,
  input  logic [DATA_W-1:0] i_ram_data_out
);
  typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, WR_LAST} state_t;
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [IW-1:0]     r_beat;
  logic [IW-1:0]     w_next;
  logic              r_ram_read;
  logic              r_ram_write;
  logic              r_wdata_req;
  logic              r_wr_done;
  logic              w_rd_last;
  logic [DATA_W-1:0] r_ram_data_in;
  logic [RAM_LAT-1:0] r_dv;
  logic [IW-1:0]     r_di [RAM_LAT];
  assign w_next = r_beat + IW'(1);
  // Reads leave in order, so the last word is the tail entry tagged LAST.
  assign w_rd_last = r_dv[RAM_LAT-1] && r_di[RAM_LAT-1] == LAST;
  assign o_req_ready = i_rst_n && r_state == IDLE;
  assign o_wdata_req = r_wdata_req;
  assign o_wdata_idx = r_beat;
  assign o_rdata_valid = r_dv[RAM_LAT-1];
  assign o_rdata_idx = r_di[RAM_LAT-1];
  assign o_rdata = i_ram_data_out;
  assign o_done = w_rd_last | r_wr_done;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_read = r_ram_read;
  assign o_ram_write = r_ram_write;
  assign o_ram_data_in = r_ram_data_in;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_base <= '0;
      r_ram_addr <= '0;
      r_beat <= '0;
      r_ram_read <= 1'b0;
      r_ram_write <= 1'b0;
      r_wdata_req <= 1'b0;
      r_wr_done <= 1'b0;
      r_ram_data_in <= '0;
      r_dv <= '0;
      for (int k = 0; k < RAM_LAT; k++) r_di[k] <= '0;
    end else begin
      r_dv[0] <= r_ram_read;
      r_di[0] <= r_beat;
      for (int k = 1; k < RAM_LAT; k++) begin
        r_dv[k] <= r_dv[k-1];
        r_di[k] <= r_di[k-1];
      end
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_base <= i_req_addr & ~ADDR_W'(LINE_WORDS - 1);
          r_beat <= '0;
          if (i_req_write) begin
            r_wdata_req <= 1'b1;
            r_state <= WR;
          end else begin
            r_ram_addr <= i_req_addr & ~ADDR_W'(LINE_WORDS - 1);
            r_ram_read <= 1'b1;
            r_state <= RD;
          end
        end
        RD: if (r_beat == LAST) begin
          r_ram_read <= 1'b0;
          r_state <= RD_DRAIN;
        end else begin
          r_beat <= w_next;
          r_ram_addr <= r_base | ADDR_W'(w_next);
        end
        RD_DRAIN: if (w_rd_last) r_state <= IDLE;
        WR: begin
          r_ram_write <= 1'b1;
          r_ram_addr <= r_base | ADDR_W'(r_beat);
          r_ram_data_in <= i_wdata;
          if (r_beat == LAST) begin
            r_wdata_req <= 1'b0;
            r_wr_done <= 1'b1;
            r_state <= WR_LAST;
          end else begin
            r_beat <= w_next;
          end
        end
        WR_LAST: begin
          r_ram_write <= 1'b0;
          r_ram_data_in <= '0;
          r_wr_done <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_line_ctrl.sv
// tb_ram_line_ctrl: three controllers (RAM_LAT 1..3) each on its own memory
// model, checked against a line-level reference memory and burst timing rules.
module tb_ram_line_ctrl;
  localparam int L = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n [3];
  logic       req_valid [3];
  logic       req_ready [3];
  logic       req_write [3];
  logic [13:0] req_addr [3];
  logic       wdata_req [3];
  logic [1:0] wdata_idx [3];
  logic [9:0] wdata [3];
  logic       rdata_valid [3];
  logic [1:0] rdata_idx [3];
  logic [9:0] rdata [3];
  logic       done [3];
  logic [13:0] ram_addr [3];
  logic       ram_read [3];
  logic       ram_write [3];
  logic [9:0] ram_din [3];
  logic [9:0] ram_dout [3];
  logic [9:0] mem [3][16384];
  logic [9:0] ref_mem [3][16384];
  logic [9:0] wbuf [3][L];
  logic [9:0] pipe [3][3];
  int total = 0;
  int bad = 0;
  bit started = 0;

  task automatic check(input string tag, input int n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d observed=%0h expected=%0h t=%0t", tag, n, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    ram_line_ctrl #(.ADDR_W(14), .DATA_W(10), .LINE_WORDS(L), .RAM_LAT(g + 1)) dut (
      .i_clk(clk), .i_rst_n(rst_n[g]),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_req_write(req_write[g]), .i_req_addr(req_addr[g]),
      .o_wdata_req(wdata_req[g]), .o_wdata_idx(wdata_idx[g]), .i_wdata(wdata[g]),
      .o_rdata_valid(rdata_valid[g]), .o_rdata_idx(rdata_idx[g]), .o_rdata(rdata[g]),
      .o_done(done[g]), .o_ram_addr(ram_addr[g]), .o_ram_read(ram_read[g]),
      .o_ram_write(ram_write[g]), .o_ram_data_in(ram_din[g]), .i_ram_data_out(ram_dout[g])
    );
    assign wdata[g] = wbuf[g][wdata_idx[g]];
    assign ram_dout[g] = pipe[g][g];
    always @(posedge clk) begin
      if (ram_write[g]) mem[g][ram_addr[g]] = ram_din[g];
      pipe[g][0] <= ram_read[g] ? mem[g][ram_addr[g]] : 10'h0;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
    always @(negedge clk)
      if (started && rst_n[g]) check("rd_wr_excl", g, {31'b0, ram_read[g] & ram_write[g]}, 0);
  end

  task automatic accept(input int n, input logic w, input logic [13:0] a);
    int k = 0;
    while (req_ready[n] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", n, req_ready[n], 1);
    req_valid[n] = 1'b1;
    req_write[n] = w;
    req_addr[n] = a;
    @(negedge clk);
    req_valid[n] = 1'b0;
  endtask

  task automatic rd_body(input int n, input logic [13:0] a, input bit hold, input logic [13:0] ha);
    int lat = n + 1;
    int base = int'(a) & ~(L - 1);
    for (int c = 1; c <= L + lat + 1; c++) begin
      if (c > 1) @(negedge clk);
      check("ram_read", n, ram_read[n], (c <= L));
      if (c <= L) check("rd_addr", n, ram_addr[n], base + c - 1);
      check("ram_write_rd", n, ram_write[n], 0);
      check("rvalid", n, rdata_valid[n], (c > lat && c <= L + lat));
      if (c > lat && c <= L + lat) begin
        check("ridx", n, rdata_idx[n], c - 1 - lat);
        check("rdata", n, rdata[n], ref_mem[n][base + c - 1 - lat]);
      end
      check("rd_done", n, done[n], (c == L + lat));
      check("rd_ready", n, req_ready[n], (c == L + lat + 1));
      if (c == 1 && hold) begin
        req_valid[n] = 1'b1;
        req_write[n] = 1'b1;
        req_addr[n] = ha;
      end
    end
  endtask

  task automatic wr_body(input int n, input logic [13:0] a);
    int base = int'(a) & ~(L - 1);
    for (int c = 1; c <= L + 2; c++) begin
      if (c > 1) @(negedge clk);
      check("wdata_req", n, wdata_req[n], (c <= L));
      if (c <= L) check("wdata_idx", n, wdata_idx[n], c - 1);
      check("ram_write", n, ram_write[n], (c >= 2 && c <= L + 1));
      if (c >= 2 && c <= L + 1) begin
        check("wr_addr", n, ram_addr[n], base + c - 2);
        check("wr_data", n, ram_din[n], wbuf[n][c - 2]);
      end else check("wr_data_idle", n, ram_din[n], 0);
      check("ram_read_wr", n, ram_read[n], 0);
      check("wr_done", n, done[n], (c == L + 1));
      check("wr_ready", n, req_ready[n], (c == L + 2));
    end
    for (int i = 0; i < L; i++) ref_mem[n][base + i] = wbuf[n][i];
  endtask

  task automatic do_read(input int n, input logic [13:0] a);
    accept(n, 1'b0, a);
    rd_body(n, a, 1'b0, 14'h0);
  endtask

  task automatic do_write(input int n, input logic [13:0] a);
    accept(n, 1'b1, a);
    wr_body(n, a);
  endtask

  task automatic fill_wbuf(input int n);
    for (int i = 0; i < L; i++) wbuf[n][i] = 10'($urandom);
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      rst_n[n] = 1'b0;
      req_valid[n] = 1'b0;
      req_write[n] = 1'b0;
      req_addr[n] = '0;
      for (int i = 0; i < L; i++) wbuf[n][i] = '0;
      for (int i = 0; i < 3; i++) pipe[n][i] = '0;
      for (int i = 0; i < 16384; i++) begin
        mem[n][i] = 10'($urandom);
        ref_mem[n][i] = mem[n][i];
      end
    end
    for (int i = 0; i < L; i++) begin
      mem[0][14'h0120 + i] = 10'(17 * (i + 1));
      ref_mem[0][14'h0120 + i] = 10'(17 * (i + 1));
    end
    #1;
    for (int n = 0; n < 3; n++) begin
      check("rst_ready", n, req_ready[n], 0);
      check("rst_ram_read", n, ram_read[n], 0);
      check("rst_ram_addr", n, ram_addr[n], 0);
      check("rst_rvalid", n, rdata_valid[n], 0);
      check("rst_done", n, done[n], 0);
    end
    @(negedge clk);
    @(negedge clk);
    for (int n = 0; n < 3; n++) rst_n[n] = 1'b1;
    started = 1;
    @(negedge clk);
    do_read(0, 14'h0123);
    check("tp1_word3", 0, ref_mem[0][14'h0123], 10'h044);
    for (int i = 0; i < L; i++) wbuf[0][i] = 10'(10'h100 + i);
    do_write(0, 14'h0040);
    do_read(0, 14'h0040);
    do_read(2, 14'h3FFF);
    fill_wbuf(0);
    accept(0, 1'b0, 14'h0121);
    rd_body(0, 14'h0121, 1'b1, 14'h0202);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wr_body(0, 14'h0202);
    do_read(0, 14'h0200);
    accept(1, 1'b0, 14'h0345);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("mid_rst_read", 1, ram_read[1], 0);
    check("mid_rst_addr", 1, ram_addr[1], 0);
    check("mid_rst_rvalid", 1, rdata_valid[1], 0);
    check("mid_rst_idx", 1, rdata_idx[1], 0);
    check("mid_rst_done", 1, done[1], 0);
    check("mid_rst_ready", 1, req_ready[1], 0);
    check("mid_rst_wreq", 1, wdata_req[1], 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_rvalid", 1, rdata_valid[1], 0);
      check("post_rst_done", 1, done[1], 0);
      check("post_rst_ready", 1, req_ready[1], 1);
    end
    fill_wbuf(1);
    do_write(1, 14'h0345);
    do_read(1, 14'h0346);
    for (int r = 0; r < 30; r++) begin
      int n = int'($urandom_range(0, 2));
      logic [13:0] a = (r % 5 == 4) ? 14'($urandom) : 14'($urandom_range(0, 47));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        fill_wbuf(n);
        do_write(n, a);
      end else do_read(n, a);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
